// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: ID-stage fields in, pipeline control bundle out.
// Ports: Op_i, valid_i, RS1addr_i, RS2addr_i, RDaddr_i, RegEqual_i, mem_ready_i (to the unit);
//        EX_* (ID/EX register), MEM_* (EX/MEM register), stall_o, flush_o, Branch_o,
//        illegal_o, mem_err_o (from the unit).
// slave is the control unit; master is the datapath side.
interface pipe_control_unit_if #(
    parameter int OP_W   = 7,
    parameter int REG_AW = 5
);
    logic [OP_W-1:0]   Op_i;
    logic              valid_i;
    logic [REG_AW-1:0] RS1addr_i;
    logic [REG_AW-1:0] RS2addr_i;
    logic [REG_AW-1:0] RDaddr_i;
    logic              RegEqual_i;
    logic              mem_ready_i;
    logic [1:0]        EX_ALUOp_o;
    logic              EX_ALUSrc_o;
    logic              EX_MemRead_o;
    logic              EX_MemWrite_o;
    logic              EX_RegWrite_o;
    logic              EX_MemToReg_o;
    logic [REG_AW-1:0] EX_RDaddr_o;
    logic              MEM_MemRead_o;
    logic              MEM_MemWrite_o;
    logic              MEM_RegWrite_o;
    logic              MEM_MemToReg_o;
    logic              stall_o;
    logic              flush_o;
    logic              Branch_o;
    logic              illegal_o;
    logic              mem_err_o;

    modport slave (
        input  Op_i, valid_i, RS1addr_i, RS2addr_i, RDaddr_i, RegEqual_i, mem_ready_i,
        output EX_ALUOp_o, EX_ALUSrc_o, EX_MemRead_o, EX_MemWrite_o, EX_RegWrite_o,
               EX_MemToReg_o, EX_RDaddr_o, MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o,
               MEM_MemToReg_o, stall_o, flush_o, Branch_o, illegal_o, mem_err_o
    );

    modport master (
        output Op_i, valid_i, RS1addr_i, RS2addr_i, RDaddr_i, RegEqual_i, mem_ready_i,
        input  EX_ALUOp_o, EX_ALUSrc_o, EX_MemRead_o, EX_MemWrite_o, EX_RegWrite_o,
               EX_MemToReg_o, EX_RDaddr_o, MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o,
               MEM_MemToReg_o, stall_o, flush_o, Branch_o, illegal_o, mem_err_o
    );
endinterface

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: registered RV32 opcode decode with load-use bubbles, beq flush and memory freeze.
// Ports: clk_i (rising edge), rst_i (async, active-low), bus (pipe_control_unit_if.slave)
//        carrying the ID-stage fields in and the EX/MEM control bundle, stall/flush/branch,
//        illegal and sticky mem_err flags out.
module pipe_control_unit #(
    parameter int OP_W        = 7,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    pipe_control_unit_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    typedef struct packed {
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              mem_rd;
        logic              mem_wr;
        logic              reg_wr;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } ctl_t;

    state_t        state_q, state_d;
    ctl_t          ex_q, ex_d, id_ctl;
    logic [3:0]    mem_q, mem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          is_r, is_addi, is_lw, is_sw, is_beq, use_rs1, use_rs2, lu_hit, br;

    always_comb begin
        is_r    = bus.Op_i == OP_W'(7'b0110011);
        is_addi = bus.Op_i == OP_W'(7'b0010011);
        is_lw   = bus.Op_i == OP_W'(7'b0000011);
        is_sw   = bus.Op_i == OP_W'(7'b0100011);
        is_beq  = bus.Op_i == OP_W'(7'b1100011);
        // every legal opcode reads rs1, so this also marks a valid legal instruction
        use_rs1 = bus.valid_i && (is_r || is_addi || is_lw || is_sw || is_beq);
        use_rs2 = bus.valid_i && (is_r || is_sw || is_beq);
        id_ctl  = use_rs1 ? ctl_t'{alu_op: is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00,
                                   alu_src: is_addi || is_lw || is_sw,
                                   mem_rd: is_lw, mem_wr: is_sw,
                                   reg_wr: is_r || is_addi || is_lw,
                                   mem_to_reg: is_lw, rd: bus.RDaddr_i} : ctl_t'('0);
        lu_hit  = ex_q.mem_rd && ex_q.rd != '0 &&
                  ((use_rs1 && bus.RS1addr_i == ex_q.rd) || (use_rs2 && bus.RS2addr_i == ex_q.rd));
    end

    // state_d is the mode of the current cycle; state_q remembers the previous one
    always_comb begin
        state_d = ((mem_q[3] || mem_q[2]) && !bus.mem_ready_i) ? MEM_WAIT :
                  (lu_hit && state_q != LU_STALL) ? LU_STALL : RUN;
        ex_d    = state_d == MEM_WAIT ? ex_q : state_d == LU_STALL ? ctl_t'('0) : id_ctl;
        mem_d   = state_d == MEM_WAIT ? mem_q : {ex_q.mem_rd, ex_q.mem_wr, ex_q.reg_wr, ex_q.mem_to_reg};
        cnt_d   = state_d != MEM_WAIT ? '0 : cnt_q == CW'(MEM_TIMEOUT) ? cnt_q : cnt_q + CW'(1);
        err_d   = err_q || cnt_d == CW'(MEM_TIMEOUT);
        br      = state_d == RUN && bus.valid_i && is_beq && bus.RegEqual_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.EX_ALUOp_o    = ex_q.alu_op;
    assign bus.EX_ALUSrc_o   = ex_q.alu_src;
    assign bus.EX_MemRead_o  = ex_q.mem_rd;
    assign bus.EX_MemWrite_o = ex_q.mem_wr;
    assign bus.EX_RegWrite_o = ex_q.reg_wr;
    assign bus.EX_MemToReg_o = ex_q.mem_to_reg;
    assign bus.EX_RDaddr_o   = ex_q.rd;
    assign {bus.MEM_MemRead_o, bus.MEM_MemWrite_o, bus.MEM_RegWrite_o, bus.MEM_MemToReg_o} = mem_q;
    assign bus.stall_o       = state_d != RUN;
    assign bus.Branch_o      = br;
    assign bus.flush_o       = br;
    assign bus.illegal_o     = bus.valid_i && !use_rs1;
    assign bus.mem_err_o     = err_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed and random stimulus checked against a behavioural pipeline model.
module tb_pipe_control_unit;
    localparam int T = 4;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int checks = 0;
    int errors = 0;

    pipe_control_unit_if #(.OP_W(7), .REG_AW(5)) bus();
    pipe_control_unit #(.OP_W(7), .REG_AW(5), .MEM_TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

    always #5 clk_i = ~clk_i;

    // {aluop, alusrc, memrd, memwr, regwr, memtoreg, rd}
    typedef struct packed {
        logic [1:0] aluop;
        logic       src, mr, mw, rw, m2r;
        logic [4:0] rd;
    } ctl_t;

    ctl_t m_ex, m_mem;
    int   m_cnt;
    bit   m_err;

    function automatic ctl_t decode(input logic v, input logic [6:0] op, input logic [4:0] rd);
        if (!v) return '0;
        case (op)
            OP_R:    return {2'b10, 5'b00010, rd};
            OP_ADDI: return {2'b00, 5'b10010, rd};
            OP_LW:   return {2'b00, 5'b11011, rd};
            OP_SW:   return {2'b00, 5'b10100, rd};
            OP_BEQ:  return {2'b01, 5'b00000, rd};
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_ex();
        return {bus.EX_ALUOp_o, bus.EX_ALUSrc_o, bus.EX_MemRead_o, bus.EX_MemWrite_o,
                bus.EX_RegWrite_o, bus.EX_MemToReg_o, bus.EX_RDaddr_o};
    endfunction

    function automatic logic [3:0] dut_mem();
        return {bus.MEM_MemRead_o, bus.MEM_MemWrite_o, bus.MEM_RegWrite_o, bus.MEM_MemToReg_o};
    endfunction

    // the model: compare every negedge, then advance as the clock edge will
    always @(negedge clk_i) begin : compare
        bit   wt, lu, br, legal, u2;
        ctl_t d;
        if (!rst_i) begin
            m_ex  = '0;
            m_mem = '0;
            m_cnt = 0;
            m_err = 0;
            chk("reset_ex", {20'd0, dut_ex()}, 0);
            chk("reset_mem", {28'd0, dut_mem()}, 0);
            chk("reset_err", {31'd0, bus.mem_err_o}, 0);
        end else begin
            legal = bus.Op_i inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
            u2    = bus.Op_i inside {OP_R, OP_SW, OP_BEQ};
            d     = decode(bus.valid_i, bus.Op_i, bus.RDaddr_i);
            wt    = (m_mem.mr || m_mem.mw) && !bus.mem_ready_i;
            lu    = !wt && m_ex.mr && m_ex.rd != 0 && bus.valid_i && legal &&
                    (bus.RS1addr_i == m_ex.rd || (u2 && bus.RS2addr_i == m_ex.rd));
            br    = !wt && !lu && bus.valid_i && bus.Op_i == OP_BEQ && bus.RegEqual_i;
            chk("stall", {31'd0, bus.stall_o}, {31'd0, wt || lu});
            chk("flush", {31'd0, bus.flush_o}, {31'd0, br});
            chk("branch", {31'd0, bus.Branch_o}, {31'd0, br});
            chk("illegal", {31'd0, bus.illegal_o}, {31'd0, bus.valid_i && !legal});
            chk("ex_bundle", {20'd0, dut_ex()}, {20'd0, m_ex});
            chk("mem_bundle", {28'd0, dut_mem()}, {28'd0, m_mem.mr, m_mem.mw, m_mem.rw, m_mem.m2r});
            chk("mem_err", {31'd0, bus.mem_err_o}, {31'd0, m_err});
            if (wt) begin
                m_cnt = m_cnt < T ? m_cnt + 1 : T;
                if (m_cnt == T) m_err = 1;
            end else begin
                m_cnt = 0;
                m_mem = m_ex;
                m_ex  = lu ? '0 : d;
            end
        end
    end

    task automatic drive(input logic [6:0] op, input logic v, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic eq, input logic rdy);
        bus.Op_i        = op;
        bus.valid_i     = v;
        bus.RS1addr_i   = rs1;
        bus.RS2addr_i   = rs2;
        bus.RDaddr_i    = rd;
        bus.RegEqual_i  = eq;
        bus.mem_ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [5];
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ};
        drive(OP_R, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        rst_i = 1'b1;
        #1;
        chk("lit_reset_aluop", {30'd0, bus.EX_ALUOp_o}, 0);
        chk("lit_reset_stall", {31'd0, bus.stall_o}, 0);
        tick();
        // R then addi
        drive(OP_R, 1, 1, 2, 3, 0, 1);
        #1 chk("lit_r_stall", {31'd0, bus.stall_o}, 0);
        tick();
        chk("lit_r_aluop", {30'd0, bus.EX_ALUOp_o}, 2);
        drive(OP_ADDI, 1, 3, 0, 4, 0, 1);
        #1 chk("lit_addi_stall", {31'd0, bus.stall_o}, 0);
        tick();
        chk("lit_addi_aluop", {30'd0, bus.EX_ALUOp_o}, 0);
        chk("lit_addi_src", {31'd0, bus.EX_ALUSrc_o}, 1);
        // lw x5 ; add x6,x5,x7
        drive(OP_LW, 1, 1, 0, 5, 0, 1);
        tick();
        drive(OP_R, 1, 5, 7, 6, 0, 1);
        #1 chk("lit_lu_stall", {31'd0, bus.stall_o}, 1);
        tick();
        chk("lit_lu_bubble", {20'd0, dut_ex()}, 0);
        chk("lit_lu_release", {31'd0, bus.stall_o}, 0);
        tick();
        chk("lit_lu_add_aluop", {30'd0, bus.EX_ALUOp_o}, 2);
        chk("lit_lu_add_rd", {27'd0, bus.EX_RDaddr_o}, 6);
        // same with rd=x0
        drive(OP_LW, 1, 1, 0, 0, 0, 1);
        tick();
        drive(OP_R, 1, 0, 7, 6, 0, 1);
        #1 chk("lit_x0_nostall", {31'd0, bus.stall_o}, 0);
        tick();
        // beq taken
        drive(OP_BEQ, 1, 1, 2, 0, 1, 1);
        #1 chk("lit_beq_branch", {31'd0, bus.Branch_o}, 1);
        chk("lit_beq_flush", {31'd0, bus.flush_o}, 1);
        tick();
        chk("lit_beq_aluop", {30'd0, bus.EX_ALUOp_o}, 1);
        // sw stalled in MEM for 3 cycles
        drive(OP_SW, 1, 1, 2, 0, 0, 1);
        tick();
        drive(OP_ADDI, 1, 0, 0, 8, 0, 1);
        tick();
        drive(OP_R, 1, 1, 1, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_wait_stall", {31'd0, bus.stall_o}, 1);
            chk("lit_wait_mem_frozen", {31'd0, bus.MEM_MemWrite_o}, 1);
            chk("lit_wait_ex_frozen", {27'd0, bus.EX_RDaddr_o}, 8);
            tick();
        end
        bus.mem_ready_i = 1'b1;
        #1 chk("lit_wait_release", {31'd0, bus.stall_o}, 0);
        tick();
        chk("lit_resume_ex", {27'd0, bus.EX_RDaddr_o}, 9);
        chk("lit_resume_mem", {28'd0, dut_mem()}, 4'b0010);
        // timeout: ready low for 6 cycles
        drive(OP_SW, 1, 1, 2, 0, 0, 1);
        tick();
        drive(OP_ADDI, 1, 0, 0, 8, 0, 1);
        tick();
        bus.mem_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("lit_timeout_err", {31'd0, bus.mem_err_o}, {31'd0, i >= T});
        end
        bus.mem_ready_i = 1'b1;
        repeat (2) begin
            tick();
            chk("lit_err_sticky", {31'd0, bus.mem_err_o}, 1);
        end
        // illegal opcode
        drive(7'h7F, 1, 1, 2, 3, 0, 1);
        #1 chk("lit_illegal", {31'd0, bus.illegal_o}, 1);
        tick();
        chk("lit_illegal_bubble", {20'd0, dut_ex()}, 0);
        bus.valid_i = 1'b0;
        #1 chk("lit_invalid_not_illegal", {31'd0, bus.illegal_o}, 0);
        tick();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            int k;
            k = $urandom_range(0, 6);
            drive(k < 5 ? ops[k] : 7'($urandom), $urandom_range(0, 9) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), $urandom_range(0, 3) != 0);
            tick();
        end
        // async reset in the middle of a memory wait
        drive(OP_LW, 1, 0, 0, 5, 0, 1);
        tick();
        drive(OP_ADDI, 1, 0, 0, 1, 0, 1);
        tick();
        bus.mem_ready_i = 1'b0;
        #1 chk("lit_rst_pre_stall", {31'd0, bus.stall_o}, 1);
        #1 rst_i = 1'b0;
        #1;
        chk("lit_async_mem", {28'd0, dut_mem()}, 0);
        chk("lit_async_ex", {20'd0, dut_ex()}, 0);
        chk("lit_async_stall", {31'd0, bus.stall_o}, 0);
        chk("lit_async_err", {31'd0, bus.mem_err_o}, 0);
        tick();
        rst_i = 1'b1;
        drive(OP_R, 1, 1, 2, 3, 0, 1);
        #1 chk("lit_post_rst_run", {31'd0, bus.stall_o}, 0);
        tick();
        chk("lit_post_rst_aluop", {30'd0, bus.EX_ALUOp_o}, 2);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
